axis_pkt_trailer: RTL and testbench

// - AXI-Stream stage directly downstream of axis_fifo.
// - Forwards every packet unchanged and appends one trailer beat after the last data beat.
// - The trailer carries the packet beat count and a folded XOR checksum.
// - TLAST moves from the last data beat to the trailer beat; the sink sees packet length + 1 beats.

---
 rtl/axis_trailer_pkg.sv | 35 +++
 rtl/axis_trailer_acc.sv | 60 ++++++
 rtl/axis_pkt_trailer.sv | 116 +++++++++++
 tb/tb_axis_pkt_trailer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_trailer_pkg.sv
// Shared types and width-generic helpers for the packet trailer stage.
// Helpers work on MAX_HW-wide vectors; callers zero-extend inputs and keep the low HALF_W bits.
package axis_trailer_pkg;

    typedef enum logic {
        PASS    = 1'b0,
        TRAILER = 1'b1
    } trl_state_t;

    localparam int MAX_HW         = 128;
    localparam int MIN_DATA_WIDTH = 16;

    // Saturating increment of the low w bits of v; bits at and above w are expected to be 0.
    function automatic logic [MAX_HW-1:0] sat_inc(input logic [MAX_HW-1:0] v, input int w);
        logic [MAX_HW-1:0] mx;
        mx = '0;
        for (int i = 0; i < MAX_HW; i++) begin
            mx[i] = (i < w);
        end
        return (v == mx) ? v : v + MAX_HW'(1);
    endfunction

    // XOR of the upper half onto the lower half of a 2*hw-bit word.
    function automatic logic [MAX_HW-1:0] fold_xor(input logic [2*MAX_HW-1:0] d, input int hw);
        logic [MAX_HW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_HW; i++) begin
            if (i < hw) begin
                r[i] = d[i] ^ d[i+hw];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_trailer_acc.sv
// Per-packet accumulators: saturating beat count and folded XOR checksum.
// clr_i wins over inc_i; the two are never requested together by the top.
module axis_trailer_acc
    import axis_trailer_pkg::*;
#(
    parameter int HALF_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc_i,
    input  logic                clr_i,
    input  logic [2*HALF_W-1:0] data_i,
    output logic [HALF_W-1:0]   cnt_o,
    output logic [HALF_W-1:0]   csum_o
);

    logic [HALF_W-1:0]   cnt_q,  cnt_d;
    logic [HALF_W-1:0]   csum_q, csum_d;
    logic [MAX_HW-1:0]   cnt_ext;
    logic [2*MAX_HW-1:0] data_ext;
    logic [MAX_HW-1:0]   inc_res;
    logic [MAX_HW-1:0]   fold_res;
    logic                unused_hi;

    always_comb begin
        cnt_ext                 = '0;
        cnt_ext[HALF_W-1:0]     = cnt_q;
        data_ext                = '0;
        data_ext[2*HALF_W-1:0]  = data_i;
        inc_res                 = sat_inc(cnt_ext, HALF_W);
        fold_res                = fold_xor(data_ext, HALF_W);

        cnt_d  = cnt_q;
        csum_d = csum_q;
        if (clr_i) begin
            cnt_d  = '0;
            csum_d = '0;
        end else if (inc_i) begin
            cnt_d  = inc_res[HALF_W-1:0];
            csum_d = csum_q ^ fold_res[HALF_W-1:0];
        end
    end

    // Upper helper bits are always zero for in-range HALF_W.
    assign unused_hi = ^{inc_res[MAX_HW-1:HALF_W], fold_res[MAX_HW-1:HALF_W]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            csum_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            csum_q <= csum_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign csum_o = csum_q;

endmodule

// File: rtl/axis_pkt_trailer.sv
// AXI-Stream stage that forwards packets and appends a {beat_cnt, csum} trailer beat.
// TLAST is moved from the last data beat onto the trailer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// PASS    | forwarding data beats, accumulating count and checksum
// TRAILER | last beat taken; input blocked until the trailer loads
module axis_pkt_trailer
    import axis_trailer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] S_TDATA,
    input  logic                  S_TVALID,
    input  logic                  S_TLAST,
    output logic                  S_TREADY,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic                  M_TVALID,
    output logic                  M_TLAST,
    input  logic                  M_TREADY
);

    localparam int HALF_W = DATA_WIDTH / 2;

    if ((DATA_WIDTH < MIN_DATA_WIDTH) || ((DATA_WIDTH % 2) != 0) || (HALF_W >= MAX_HW)) begin : g_bad_width
        $error("axis_pkt_trailer: DATA_WIDTH must be even, >= 16 and < 2*MAX_HW");
    end

    trl_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] m_tdata_q,  m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q,  m_tlast_d;
    logic                  free;
    logic                  s_ready_fsm;
    logic                  acc_inc;
    logic                  acc_clr;
    logic [HALF_W-1:0]     beat_cnt;
    logic [HALF_W-1:0]     csum;

    assign free = !m_tvalid_q || M_TREADY;

    axis_trailer_acc #(
        .HALF_W (HALF_W)
    ) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (acc_inc),
        .clr_i   (acc_clr),
        .data_i  (S_TDATA),
        .cnt_o   (beat_cnt),
        .csum_o  (csum)
    );

    always_comb begin
        state_d     = state_q;
        m_tdata_d   = m_tdata_q;
        m_tlast_d   = m_tlast_q;
        m_tvalid_d  = m_tvalid_q;
        s_ready_fsm = 1'b0;
        acc_inc     = 1'b0;
        acc_clr     = 1'b0;

        if (free) begin
            m_tvalid_d = 1'b0;
        end

        unique case (state_q)
            PASS: begin
                s_ready_fsm = free;
                if (S_TVALID && free) begin
                    m_tdata_d  = S_TDATA;
                    m_tlast_d  = 1'b0;
                    m_tvalid_d = 1'b1;
                    acc_inc    = 1'b1;
                    if (S_TLAST) begin
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                // Accumulators hold while the output register is occupied.
                if (free) begin
                    m_tdata_d  = {beat_cnt, csum};
                    m_tlast_d  = 1'b1;
                    m_tvalid_d = 1'b1;
                    acc_clr    = 1'b1;
                    state_d    = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PASS;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    // Ready is forced high during reset so the upstream FIFO sees a defined level.
    assign S_TREADY = !reset_n || s_ready_fsm;
    assign M_TDATA  = m_tdata_q;
    assign M_TVALID = m_tvalid_q;
    assign M_TLAST  = m_tlast_q;

endmodule

// File: tb/tb_axis_pkt_trailer.sv
// Bench for axis_pkt_trailer: queue-based packet model plus literal trailer checks.
module tb_axis_pkt_trailer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;

    logic [15:0] s16_tdata;
    logic        s16_tvalid, s16_tlast, s16_tready;
    logic [15:0] m16_tdata;
    logic        m16_tvalid, m16_tlast, m16_tready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_pkt_trailer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .S_TDATA(s_tdata), .S_TVALID(s_tvalid), .S_TLAST(s_tlast), .S_TREADY(s_tready),
        .M_TDATA(m_tdata), .M_TVALID(m_tvalid), .M_TLAST(m_tlast), .M_TREADY(m_tready)
    );

    axis_pkt_trailer #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n),
        .S_TDATA(s16_tdata), .S_TVALID(s16_tvalid), .S_TLAST(s16_tlast), .S_TREADY(s16_tready),
        .M_TDATA(m16_tdata), .M_TVALID(m16_tvalid), .M_TLAST(m16_tlast), .M_TREADY(m16_tready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    // ---------------- model: expected output beats {last, data} ----------------
    logic [32:0] exp_q[$];
    logic [31:0] trl_log[$];
    int          mdl_cnt  = 0;
    logic [15:0] mdl_csum = '0;
    int          trl_cnt  = 0;
    int          zero_cnt = 0;
    logic        have_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_valid, prev_ready, prev_last;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            mdl_cnt   = 0;
            mdl_csum  = '0;
            have_prev = 1'b0;
        end else begin
            if (have_prev && prev_valid && !prev_ready) begin
                chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
                chk("stall_data", m_tdata, prev_data);
                chk("stall_last", {31'd0, m_tlast}, {31'd0, prev_last});
            end
            if (m_tvalid && !m_tready) begin
                chk("stall_s_tready", {31'd0, s_tready}, 32'd0);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_tdata, 32'hDEADBEEF);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", m_tdata, e[31:0]);
                    chk("out_last", {31'd0, m_tlast}, {31'd0, e[32]});
                end
                if (m_tlast) begin
                    trl_log.push_back(m_tdata);
                    trl_cnt++;
                end
            end
            if (s_tvalid && s_tready) begin
                exp_q.push_back({1'b0, s_tdata});
                if (mdl_cnt < 65535) mdl_cnt++;
                mdl_csum = mdl_csum ^ s_tdata[31:16] ^ s_tdata[15:0];
                if (s_tlast) begin
                    exp_q.push_back({1'b1, mdl_cnt[15:0], mdl_csum});
                    mdl_cnt  = 0;
                    mdl_csum = '0;
                end
            end
            if (s_tvalid && !s_tready) zero_cnt++;
            prev_data  = m_tdata;
            prev_valid = m_tvalid;
            prev_ready = m_tready;
            prev_last  = m_tlast;
            have_prev  = 1'b1;
        end
    end

    // ---------------- 16-bit instance observer ----------------
    int          n16_out = 0;
    int          n16_bad = 0;
    int          n16_trl = 0;
    logic [15:0] trl16   = '0;

    always @(negedge clk) begin
        if (reset_n && m16_tvalid && m16_tready) begin
            n16_out++;
            if (m16_tlast) begin
                trl16 = m16_tdata;
                n16_trl++;
            end else if (m16_tdata != 16'h0000) begin
                n16_bad++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input logic [31:0] d, input logic l);
        int   n;
        logic acc;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_trailers(input int target);
        int n;
        n = 0;
        while (trl_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("trailer_wait", {31'd0, trl_cnt >= target}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        n_err++;
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int zc;
        int n;
        logic acc;

        reset_n    = 1'b0;
        s_tdata    = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        s16_tdata  = '0; s16_tvalid = 1'b0; s16_tlast = 1'b0; m16_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_s_tready", {31'd0, s_tready}, 32'd1);
        chk("rst16_m_tdata", {16'd0, m16_tdata}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 3-beat packet followed immediately by a 1-beat packet: exactly one input bubble
        zc = zero_cnt;
        send_beat(32'h00010002, 1'b0);
        send_beat(32'h00030004, 1'b0);
        send_beat(32'h00050006, 1'b1);
        send_beat(32'h00000000, 1'b1);
        chk("pkt3_bubbles", zero_cnt - zc, 32'd1);
        wait_trailers(2);
        chk("pkt3_trailer", trl_log[0], 32'h00030007);
        chk("pkt1_zero_trailer", trl_log[1], 32'h00010000);

        // single-beat packet
        send_beat(32'hA5A50000, 1'b1);
        wait_trailers(3);
        chk("single_trailer", trl_log[2], 32'h0001A5A5);

        // stalls mid-packet, in TRAILER state, and with the trailer held on the output
        fork
            begin
                send_beat(32'h11112222, 1'b0);
                send_beat(32'h33334444, 1'b0);
                send_beat(32'h55556666, 1'b0);
                send_beat(32'h77778888, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1 m_tready = 1'b0;
                repeat (5) @(posedge clk);
                #1 m_tready = 1'b1;
                n = 0;
                acc = 1'b0;
                while (!acc && n < 200) begin
                    @(negedge clk);
                    acc = s_tvalid && s_tlast && s_tready;
                    n++;
                end
                @(posedge clk);
                #1 m_tready = 1'b0;
                repeat (5) @(posedge clk);
                #1 m_tready = 1'b1;
                @(posedge clk);
                #1 m_tready = 1'b0;
                repeat (3) @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        wait_trailers(4);
        chk("stall_trailer", trl_log[3], 32'h00048888);

        // back-to-back 2-beat packets of all ones
        zc = zero_cnt;
        send_beat(32'hFFFFFFFF, 1'b0);
        send_beat(32'hFFFFFFFF, 1'b1);
        send_beat(32'hFFFFFFFF, 1'b0);
        send_beat(32'hFFFFFFFF, 1'b1);
        chk("b2b_bubbles", zero_cnt - zc, 32'd1);
        wait_trailers(6);
        chk("b2b_trailer0", trl_log[4], 32'h00020000);
        chk("b2b_trailer1", trl_log[5], 32'h00020000);

        // reset after beat 2 of 4: partial packet dropped
        send_beat(32'h0000AAAA, 1'b0);
        send_beat(32'h0000BBBB, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("async_rst_s_tready", {31'd0, s_tready}, 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("no_trailer_after_rst", trl_cnt, 32'd6);
        send_beat(32'h00000001, 1'b1);
        wait_trailers(7);
        chk("post_rst_trailer", trl_log[6], 32'h00010001);
        repeat (4) @(posedge clk);
        #1;
        chk("model_drained", exp_q.size(), 32'd0);
        chk("total_trailers", trl_cnt, 32'd7);

        // saturation on the 16-bit instance: 300 zero beats
        for (int i = 0; i < 300; i++) begin
            s16_tdata  = 16'h0000;
            s16_tlast  = (i == 299);
            s16_tvalid = 1'b1;
            n = 0;
            acc = 1'b0;
            while (!acc && n < 50) begin
                @(negedge clk);
                acc = s16_tready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) chk("sat_send_timeout", 32'd0, 32'd1);
        end
        s16_tvalid = 1'b0;
        s16_tlast  = 1'b0;
        n = 0;
        while (n16_trl < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sat_trailer", {16'd0, trl16}, 32'h0000FF00);
        chk("sat_beats_out", n16_out, 32'd301);
        chk("sat_data_zero", n16_bad, 32'd0);

        summary();
        $finish;
    end

endmodule
